// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: frame constants and FSM state encoding.
// Optional feature macro: UART_RX_PARITY_EN (adds the even-parity bit and PARITY state).
package uart_rx_pkg;

    localparam int UART_DATA_W  = 8;
    localparam int UART_OVS     = 16;
    localparam int UART_OVS_MID = 7;

    // Receiver FSM states; the encoding is stable so checkers can bind to it.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    // Even parity over data plus parity bit: 1 means the check failed.
    function automatic logic parity_fail(input logic [UART_DATA_W-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/rx_oversample_tick.sv
// Fractional-accumulator 16x baud tick generator for the UART receiver.
// The carry out of the ACC_W-bit fraction is the tick; cleared while disabled.
module rx_oversample_tick #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600,
    parameter int ACC_W    = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam logic [63:0] INC_FULL =
        ((64'(BAUD) * 64'd16) << (ACC_W - 7)) / (64'(CLK_FREQ) >> 7);
    localparam logic [ACC_W-1:0] OVS_INC = INC_FULL[ACC_W-1:0];

    logic [ACC_W:0] acc;

    // Accumulate the fraction each clock; bit ACC_W holds the carry for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (!enable) begin
            acc <= '0;
        end else begin
            acc <= {1'b0, acc[ACC_W-1:0]} + {1'b0, OVS_INC};
        end
    end

    assign tick = acc[ACC_W];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined), LSB first, 16x oversampled.
// Handshake: data_ready rises with a new good byte and holds until the consumer pulses
// data_read for one cycle; data_ready and overrun clear on the following clock, but a
// byte completing in that same cycle wins (data_ready stays 1, overrun 0).
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600,
    parameter int ACC_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   rx,
    input  logic                   data_read,
    output logic [UART_DATA_W-1:0] data,
    output logic                   data_ready,
    output logic                   overrun,
    output logic                   frame_error,
    output logic                   parity_error
);

    localparam logic [3:0] SC_MID = 4'(UART_OVS_MID);
    localparam logic [3:0] SC_END = 4'(UART_OVS - 1);
    localparam logic [2:0] BIT_LAST = 3'(UART_DATA_W - 1);

    logic rx_m, rx_s;
    logic tick;

    rx_state_t              state, state_nx;
    logic [3:0]             sc, sc_nx;
    logic [2:0]             bit_idx, bit_idx_nx;
    logic [UART_DATA_W-1:0] shift, shift_nx;
    logic [UART_DATA_W-1:0] data_nx;
    logic                   data_ready_nx, overrun_nx;
    logic                   frame_error_nx, parity_error_nx;
    logic                   par_err;
`ifdef UART_RX_PARITY_EN
    logic                   par_err_nx;
`endif

    // Two-flop synchronizer for the asynchronous line; resets to the idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    rx_oversample_tick #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD),
        .ACC_W   (ACC_W)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .enable(enable),
        .tick  (tick)
    );

    // State, counters, shift register and handshake/status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sc           <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            data         <= '0;
            data_ready   <= 1'b0;
            overrun      <= 1'b0;
            frame_error  <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            state        <= state_nx;
            sc           <= sc_nx;
            bit_idx      <= bit_idx_nx;
            shift        <= shift_nx;
            data         <= data_nx;
            data_ready   <= data_ready_nx;
            overrun      <= overrun_nx;
            frame_error  <= frame_error_nx;
            parity_error <= parity_error_nx;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity check result of the current frame, consumed at the stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_err <= 1'b0;
        else        par_err <= par_err_nx;
    end
`else
    assign par_err = 1'b0;
`endif

    // Next-state logic. After the start bit is confirmed at its middle, sc restarts at 0,
    // so every later sample (sc==15 on a tick) lands 16 ticks on, i.e. mid-bit.
    always_comb begin
        state_nx        = state;
        sc_nx           = sc;
        bit_idx_nx      = bit_idx;
        shift_nx        = shift;
        data_nx         = data;
        data_ready_nx   = data_ready;
        overrun_nx      = overrun;
        frame_error_nx  = 1'b0;
        parity_error_nx = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_nx      = par_err;
`endif

        if (data_read) begin
            data_ready_nx = 1'b0;
            overrun_nx    = 1'b0;
        end

        if (!enable) begin
            state_nx = IDLE;
            sc_nx    = '0;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    sc_nx = '0;
                    if (!rx_s) state_nx = START;
                end
                START: begin
                    if (sc == SC_MID) begin
                        sc_nx = '0;
                        if (rx_s) begin
                            state_nx = IDLE;
                        end else begin
                            bit_idx_nx = '0;
                            state_nx   = DATA;
                        end
                    end else begin
                        sc_nx = sc + 4'd1;
                    end
                end
                DATA: begin
                    sc_nx = sc + 4'd1;
                    if (sc == SC_END) begin
                        shift_nx   = {rx_s, shift[UART_DATA_W-1:1]};
                        bit_idx_nx = bit_idx + 3'd1;
                        if (bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_nx = PARITY;
`else
                            state_nx = STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    sc_nx = sc + 4'd1;
                    if (sc == SC_END) begin
                        par_err_nx = parity_fail(shift, rx_s);
                        state_nx   = STOP;
                    end
                end
`endif
                STOP: begin
                    sc_nx = sc + 4'd1;
                    if (sc == SC_END) begin
                        sc_nx = '0;
                        if (rx_s) begin
                            if (par_err) begin
                                parity_error_nx = 1'b1;
                            end else begin
                                data_nx       = shift;
                                data_ready_nx = 1'b1;
                                overrun_nx    = data_ready && !data_read;
                            end
                            state_nx = IDLE;
                        end else begin
                            frame_error_nx  = 1'b1;
                            parity_error_nx = par_err;
                            state_nx        = BREAK;
                        end
                    end
                end
                BREAK: begin
                    sc_nx = '0;
                    if (rx_s) state_nx = IDLE;
                end
                default: begin
                    sc_nx    = '0;
                    state_nx = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 3.2 MHz / 100 kbit/s (tick every 2 clk, 32 clk per bit).
module tb_uart_rx;

    localparam int BIT_CLK = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       rx = 1'b1;
    logic       data_read = 1'b0;
    logic [7:0] data;
    logic       data_ready;
    logic       overrun;
    logic       frame_error;
    logic       parity_error;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int fe_cnt = 0;
    int pe_cnt = 0;
    int rise_cyc = 0;
    int start_cyc = 0;
    logic dr_prev = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx #(
        .CLK_FREQ(3200000),
        .BAUD    (100000),
        .ACC_W   (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .rx          (rx),
        .data_read   (data_read),
        .data        (data),
        .data_ready  (data_ready),
        .overrun     (overrun),
        .frame_error (frame_error),
        .parity_error(parity_error)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters and data_ready rise capture, sampled away from the active edge.
    always @(negedge clk) begin
        if (frame_error) fe_cnt = fe_cnt + 1;
        if (parity_error) pe_cnt = pe_cnt + 1;
        if (data_ready && !dr_prev) rise_cyc = cyc;
        dr_prev = data_ready;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_clk(BIT_CLK);
    endtask

    // Full frame; a good frame (valid parity and stop) is pushed on the expected queue.
    task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic stop);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^b) ^ !par_ok);
`endif
        send_bit(stop);
        if (stop) rx = 1'b1;
`ifdef UART_RX_PARITY_EN
        if (stop && par_ok) exp_q.push_back(b);
`else
        if (stop) exp_q.push_back(b);
`endif
    endtask

    task automatic expect_byte(input string tag);
        logic [7:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check(tag, {24'd0, data}, {24'd0, e});
    endtask

    task automatic pulse_read();
        data_read = 1'b1;
        wait_clk(1);
        data_read = 1'b0;
        wait_clk(1);
    endtask

    initial begin
        // 1: reset and quiet line
        rst_n = 1'b0; enable = 1'b1; rx = 1'b1; data_read = 1'b0;
        wait_clk(5);
        check("rst_data", {24'd0, data}, 32'h0);
        check("rst_ready", {31'd0, data_ready}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_ferr", {31'd0, frame_error}, 32'd0);
        check("rst_perr", {31'd0, parity_error}, 32'd0);
        rst_n = 1'b1;
        wait_clk(1000);
        check("idle_ready", {31'd0, data_ready}, 32'd0);
        check("idle_pulses", fe_cnt + pe_cnt, 32'd0);

        // 2: one byte, latency from start edge to data_ready (stop mid-bit is +304 clk)
        send_frame(8'hA5, 1'b1, 1'b1);
        wait_clk(16);
        expect_byte("a5_data");
        check("a5_ready", {31'd0, data_ready}, 32'd1);
`ifdef UART_RX_PARITY_EN
        check("a5_latency", {31'd0, (rise_cyc - start_cyc >= 336) && (rise_cyc - start_cyc <= 340)}, 32'd1);
`else
        check("a5_latency", {31'd0, (rise_cyc - start_cyc >= 304) && (rise_cyc - start_cyc <= 308)}, 32'd1);
`endif
        pulse_read();
        check("a5_read", {31'd0, data_ready}, 32'd0);

        // 3: short glitch rejected, then a normal byte
        rx = 1'b0;
        wait_clk(10);
        rx = 1'b1;
        wait_clk(100);
        check("glitch_ready", {31'd0, data_ready}, 32'd0);
        check("glitch_pulses", fe_cnt + pe_cnt, 32'd0);
        send_frame(8'h3C, 1'b1, 1'b1);
        wait_clk(16);
        expect_byte("3c_data");
        pulse_read();

        // 4: stop bit low, line held in break, then recovery
        fe_cnt = 0;
        send_frame(8'h55, 1'b1, 1'b0);
        wait_clk(200);
        rx = 1'b1;
        wait_clk(64);
        check("fe_count", fe_cnt, 32'd1);
        check("fe_ready", {31'd0, data_ready}, 32'd0);
        check("fe_data", {24'd0, data}, 32'h3C);
        send_frame(8'h12, 1'b1, 1'b1);
        wait_clk(16);
        expect_byte("12_data");
        pulse_read();

        // 5: overrun on two unread bytes
        send_frame(8'h11, 1'b1, 1'b1);
        wait_clk(8);
        expect_byte("11_data");
        check("ovr_first", {31'd0, overrun}, 32'd0);
        send_frame(8'h22, 1'b1, 1'b1);
        wait_clk(16);
        expect_byte("22_data");
        check("ovr_ready", {31'd0, data_ready}, 32'd1);
        check("ovr_set", {31'd0, overrun}, 32'd1);
        pulse_read();
        check("ovr_clr_ready", {31'd0, data_ready}, 32'd0);
        check("ovr_clr", {31'd0, overrun}, 32'd0);

        // 6: parity error, then good parity
`ifdef UART_RX_PARITY_EN
        pe_cnt = 0;
        send_frame(8'h07, 1'b0, 1'b1);
        wait_clk(16);
        check("par_count", pe_cnt, 32'd1);
        check("par_ready", {31'd0, data_ready}, 32'd0);
        check("par_data", {24'd0, data}, 32'h22);
        send_frame(8'h07, 1'b1, 1'b1);
        wait_clk(16);
        expect_byte("07_data");
        pulse_read();
`else
        check("par_tied", pe_cnt, 32'd0);
`endif

        // Reset in the middle of a frame, then a clean frame
        send_frame(8'h99, 1'b1, 1'b1);
        wait_clk(16);
        expect_byte("99_data");
        rx = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        rst_n = 1'b0;
        wait_clk(3);
        check("mid_rst_data", {24'd0, data}, 32'h0);
        check("mid_rst_ready", {31'd0, data_ready}, 32'd0);
        rst_n = 1'b1;
        rx = 1'b1;
        wait_clk(100);
        check("post_rst_ready", {31'd0, data_ready}, 32'd0);
        send_frame(8'hC3, 1'b1, 1'b1);
        wait_clk(16);
        expect_byte("c3_data");
        check("c3_ready", {31'd0, data_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
